// File: rtl/vote_tally_pkg.sv
// Shared types and defaults for the vote tally block.
package vote_tally_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_CLOSED = 2'd2
    } state_e;

    localparam int NUM_CAND_DEF = 4;
    localparam int CNT_W_DEF    = 8;
    localparam int ID_W_DEF     = 8;

    localparam logic MODE_VOTE   = 1'b0;
    localparam logic MODE_RESULT = 1'b1;

endpackage

// File: rtl/vote_tally_sat_counter.sv
// Saturating up-counter; sat_o flags an increment request that hit the ceiling.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             at_max;

    assign at_max = &cnt_q;
    assign cnt_o  = cnt_q;
    assign sat_o  = en_i && at_max;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (en_i && !at_max) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Commits validated vote strobes to per-candidate counters, tracks who has
// voted, and presents a selected candidate's count in result mode.
module vote_tally
    import vote_tally_pkg::*;
#(
    parameter int NUM_CAND = NUM_CAND_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int SEL_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 mode_i,
    input  logic                 pollsig_i,
    input  logic [ID_W-1:0]      voter_id_i,
    input  logic [NUM_CAND-1:0]  valid_vote_i,
    input  logic [SEL_W-1:0]     sel_cand_i,
    output logic [2**ID_W-1:0]   voted_o,
    output logic [CNT_W-1:0]     count_out_o,
    output logic [ID_W:0]        total_votes_o,
    output logic                 vote_ack_o,
    output logic                 vote_err_o,
    output logic                 overflow_o
);

    state_e               state_q;
    logic [2**ID_W-1:0]   voted_q;
    logic [ID_W:0]        total_q;
    logic [CNT_W-1:0]     count_out_q;
    logic                 vote_ack_q;
    logic                 vote_err_q;
    logic                 overflow_q;

    logic                 onehot;
    logic                 commit;
    logic                 reject;
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     cnt_w [NUM_CAND];
    logic [NUM_CAND-1:0]  sat_w;

    always_comb begin
        onehot = (valid_vote_i != '0) &&
                 ((valid_vote_i & (valid_vote_i - NUM_CAND'(1))) == '0);
        commit = (state_q == ST_OPEN) && pollsig_i && (mode_i == MODE_VOTE) &&
                 onehot && !voted_q[voter_id_i];
        reject = (valid_vote_i != '0) && !commit;
    end

    for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .en_i    (commit && valid_vote_i[k]),
            .cnt_o   (cnt_w[k]),
            .sat_o   (sat_w[k])
        );
    end

    // Out-of-range selections show zero rather than aliasing another candidate.
    always_comb begin
        count_d = '0;
        if (mode_i == MODE_RESULT && int'(sel_cand_i) < NUM_CAND) begin
            count_d = cnt_w[sel_cand_i];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            voted_q     <= '0;
            total_q     <= '0;
            count_out_q <= '0;
            vote_ack_q  <= 1'b0;
            vote_err_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            vote_ack_q  <= commit;
            vote_err_q  <= reject;
            count_out_q <= count_d;
            overflow_q  <= overflow_q | (|sat_w);
            if (commit) begin
                voted_q[voter_id_i] <= 1'b1;
                total_q             <= total_q + (ID_W+1)'(1);
            end
            // CLOSED is left only through reset so the bitmap cannot be reused.
            case (state_q)
                ST_IDLE:   if (pollsig_i)  state_q <= ST_OPEN;
                ST_OPEN:   if (!pollsig_i) state_q <= ST_CLOSED;
                ST_CLOSED: state_q <= ST_CLOSED;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign voted_o       = voted_q;
    assign total_votes_o = total_q;
    assign count_out_o   = count_out_q;
    assign vote_ack_o    = vote_ack_q;
    assign vote_err_o    = vote_err_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: default build plus a 2-bit counter build.
module tb_vote_tally;

    logic         clock;
    logic         reset;
    logic         mode, pollsig;
    logic [7:0]   voter_id;
    logic [3:0]   valid_vote;
    logic [1:0]   sel_cand;
    logic [255:0] voted;
    logic [7:0]   count_out;
    logic [8:0]   total_votes;
    logic         vote_ack, vote_err, overflow;

    logic         b_reset, b_mode, b_pollsig;
    logic [7:0]   b_voter_id;
    logic [3:0]   b_valid_vote;
    logic [1:0]   b_sel_cand;
    logic [255:0] b_voted;
    logic [1:0]   b_count_out;
    logic [8:0]   b_total_votes;
    logic         b_vote_ack, b_vote_err, b_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    vote_tally u_dut (
        .clock_i(clock), .reset_i(reset), .mode_i(mode), .pollsig_i(pollsig),
        .voter_id_i(voter_id), .valid_vote_i(valid_vote), .sel_cand_i(sel_cand),
        .voted_o(voted), .count_out_o(count_out), .total_votes_o(total_votes),
        .vote_ack_o(vote_ack), .vote_err_o(vote_err), .overflow_o(overflow)
    );

    vote_tally #(.CNT_W(2)) u_dut_sat (
        .clock_i(clock), .reset_i(b_reset), .mode_i(b_mode), .pollsig_i(b_pollsig),
        .voter_id_i(b_voter_id), .valid_vote_i(b_valid_vote), .sel_cand_i(b_sel_cand),
        .voted_o(b_voted), .count_out_o(b_count_out), .total_votes_o(b_total_votes),
        .vote_ack_o(b_vote_ack), .vote_err_o(b_vote_err), .overflow_o(b_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; pollsig = 1'b0; voter_id = '0;
        valid_vote = '0; sel_cand = '0;
        b_reset = 1'b1; b_mode = 1'b0; b_pollsig = 1'b0; b_voter_id = '0;
        b_valid_vote = '0; b_sel_cand = '0;
        tick();
        chk("rst_ack",   32'(vote_ack), 0);
        chk("rst_err",   32'(vote_err), 0);
        chk("rst_total", 32'(total_votes), 0);
        chk("rst_voted", 32'(|voted), 0);
        chk("rst_cnt",   32'(count_out), 0);
        chk("rst_ovf",   32'(overflow), 0);

        reset = 1'b0; pollsig = 1'b1;
        tick();                                   // IDLE -> OPEN
        voter_id = 8'd5; valid_vote = 4'b0001;
        tick();
        chk("v5_ack",   32'(vote_ack), 1);
        chk("v5_err",   32'(vote_err), 0);
        chk("v5_voted", 32'(voted[5]), 1);
        chk("v5_total", 32'(total_votes), 1);
        valid_vote = '0;
        tick();
        chk("v5_ack_one", 32'(vote_ack), 0);

        voter_id = 8'd5; valid_vote = 4'b0010;
        tick();
        chk("rep5_err",   32'(vote_err), 1);
        chk("rep5_ack",   32'(vote_ack), 0);
        chk("rep5_total", 32'(total_votes), 1);

        voter_id = 8'd7; valid_vote = 4'b0110;
        tick();
        chk("multi_err",   32'(vote_err), 1);
        chk("multi_voted", 32'(voted[7]), 0);
        chk("multi_total", 32'(total_votes), 1);
        valid_vote = '0;

        mode = 1'b1; sel_cand = 2'd0;
        tick();
        chk("res_c0", 32'(count_out), 1);
        sel_cand = 2'd1;
        tick();
        chk("res_c1", 32'(count_out), 0);
        voter_id = 8'd8; valid_vote = 4'b0001;
        tick();
        chk("res_err",   32'(vote_err), 1);
        chk("res_total", 32'(total_votes), 1);
        chk("res_voted", 32'(voted[8]), 0);
        valid_vote = '0; mode = 1'b0;
        tick();
        chk("vote_cnt0", 32'(count_out), 0);

        voter_id = 8'd10; valid_vote = 4'b0100;
        tick();
        chk("v10_ack", 32'(vote_ack), 1);
        voter_id = 8'd11; valid_vote = 4'b1000;   // held two cycles
        tick();
        chk("v11_ack", 32'(vote_ack), 1);
        tick();
        chk("v11_hold_err", 32'(vote_err), 1);
        chk("v11_hold_ack", 32'(vote_ack), 0);
        chk("v11_total",    32'(total_votes), 3);
        valid_vote = '0;

        pollsig = 1'b0; voter_id = 8'd12; valid_vote = 4'b0001;
        tick();
        chk("fall_err",   32'(vote_err), 1);
        chk("fall_voted", 32'(voted[12]), 0);
        valid_vote = '0; pollsig = 1'b1;
        tick();
        voter_id = 8'd9; valid_vote = 4'b0001;
        tick();
        chk("closed_err",   32'(vote_err), 1);
        chk("closed_voted", 32'(voted[9]), 0);
        chk("closed_total", 32'(total_votes), 3);
        valid_vote = '0;

        mode = 1'b1; sel_cand = 2'd3;
        tick();
        chk("res_c3", 32'(count_out), 1);
        #3 reset = 1'b1;
        #1;
        chk("async_total", 32'(total_votes), 0);
        chk("async_voted", 32'(|voted), 0);
        chk("async_cnt",   32'(count_out), 0);
        #2 reset = 1'b0; mode = 1'b0;
        tick();                                   // IDLE -> OPEN
        voter_id = 8'd9; valid_vote = 4'b0001;
        tick();
        chk("v9_ack",   32'(vote_ack), 1);
        chk("v9_voted", 32'(voted[9]), 1);
        valid_vote = '0;

        b_reset = 1'b0; b_pollsig = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            b_voter_id = 8'(i); b_valid_vote = 4'b0100;
            tick();
            chk($sformatf("sat_ack%0d", i), 32'(b_vote_ack), 1);
            b_valid_vote = '0;
            tick();
        end
        chk("sat_total", 32'(b_total_votes), 4);
        chk("sat_ovf",   32'(b_overflow), 1);
        b_mode = 1'b1; b_sel_cand = 2'd2;
        tick();
        chk("sat_cnt2", 32'(b_count_out), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
